adc_lvds_serializer: RTL and testbench
======================================

# adc_lvds_serializer

Bit-rate serializer for multi-lane LVDS ADC data: the transmit end of the ADC data interface. It accepts one parallel sample per channel per frame through a valid/ready handshake and drives the per-lane serial data and the frame clock level. Its output format is the one our LVDS ADC receiver deserializes, so the block serves both as an FPGA-resident ADC emulator and as a loopback source for receiver bring-up. DCLK itself is not generated here: it is forwarded from SysClk by an external ODDR.

## Interface
- C_AdcChnls, 2: number of ADC channels.
- C_AdcWireInt, 2: serial lanes per channel.
- C_AdcBits, 16: sample width. Must be a multiple of C_AdcWireInt.
- C_AdcBytOrBitMode, 1: lane mapping. 1 = byte-wise, 0 = bit-wise.
- C_AdcMsbOrLsbFst, 1: serial bit order. 1 = MSB first, 0 = LSB first.
- SysClk  in  1  bit-rate clock; one serial bit per lane per cycle.
- SysRst  in  1  synchronous, active-high reset.
- S_Data  in  C_AdcChnls*C_AdcBits  samples; channel c occupies [c*C_AdcBits +: C_AdcBits].
- S_Valid  in  1  sample word valid.
- S_Ready  out  1  sample word accepted when S_Valid && S_Ready.
- Data  out  C_AdcChnls*C_AdcWireInt  serial lanes; lane k of channel c is Data[c*C_AdcWireInt+k].
- Fclk  out  1  frame clock level.
- FrameStart  out  1  one-cycle pulse coincident with the first bit of each frame.
- Underflow  out  1  sticky flag: a frame boundary was reached without a valid sample.

## Operation
- N = C_AdcBits/C_AdcWireInt bits per lane per frame. BitCnt counts 0..N-1 and wraps.
- **Byte-wise lane mapping:** lane k carries sample bits [(k+1)*N-1 : k*N].
- **Bit-wise lane mapping:** lane k carries bits k, k+W, k+2W, ..., where W = C_AdcWireInt.
- **Bit order:** MSB first emits the highest-indexed bit of the lane's set first. LSB first emits the lowest-indexed bit first.
- **IDLE state** (entered at reset):
  - Data=0, Fclk=0, FrameStart=0, S_Ready=1.
  - A handshake moves the block to RUN.
- **RUN state:**
  - A shift register per lane is loaded at each frame boundary.
  - S_Ready=1 only in the cycle where BitCnt==N-1.
  - Handshake in that cycle: the new sample is loaded.
  - No S_Valid in that cycle: the previous sample is retransmitted, Underflow is set, and framing continues uninterrupted.
- **Fclk:** 1 while BitCnt < ceil(N/2), else 0.
- **Leaving RUN:** only by reset. Underflow clears only on reset.
- **S_Data hold:** S_Data must be held stable while S_Valid=1 and S_Ready=0. The block samples it only on the handshake.

## Timing
- Handshake at cycle t → first bit on Data, Fclk=1 and FrameStart=1 at t+1. All outputs are registered.
- The frame period is exactly N cycles, and consecutive frames are gapless.
- Reset asserted mid-frame: on the next edge all outputs take their reset values (Data=0, Fclk=0, FrameStart=0, Underflow=0, S_Ready=1) and the partial frame is dropped.
- Handshake in the same cycle as SysRst: ignored.
- Underflow rises in the cycle after the missed boundary, coincident with FrameStart of the repeated frame.

## Configuration
- ADC_SER_TESTPAT_EN defined:
  - Adds input TestPatEn (1 bit).
  - While TestPatEn=1, each frame-boundary load takes an internal C_AdcBits ramp instead of S_Data.
  - The ramp is common to all channels, starts at 0 after reset, and increments by 1 per frame with wrap at 2^C_AdcBits-1 → 0.
  - In this mode S_Ready stays 0 and Underflow is not set.
  - The ramp advances only while TestPatEn=1.
  - TestPatEn is sampled at the frame boundary (BitCnt==N-1) and in IDLE. Asserting it in IDLE starts RUN.
- Not defined: no port and no ramp logic; behaviour is as if TestPatEn=0.

## Structure
- Package adc_lvds_pkg holds:
  - mode encodings ADC_MODE_BYTE=1, ADC_MODE_BIT=0, ADC_ORDER_MSB=1, ADC_ORDER_LSB=0;
  - state typedef (IDLE, RUN);
  - a function computing N and ceil(N/2).
- Sub-module adc_lane_shifter, one instance per channel: C_AdcBits load, lane permutation by mode/order, and C_AdcWireInt parallel shift registers.
- The top level holds the FSM, BitCnt, handshake, Fclk/FrameStart, Underflow and the ramp.

## Test plan
All cases use C_AdcChnls=2, C_AdcWireInt=2, C_AdcBits=16, so N=8.
- **Byte-wise, MSB first:** ch0=16'hA5C3 → lane1 emits 1,0,1,0,0,1,0,1; lane0 emits 1,1,0,0,0,0,1,1. Fclk reads 1,1,1,1,0,0,0,0.
- **Bit-wise, LSB first:** ch1=16'h0001 → lane2 emits 1,0,0,0,0,0,0,0; lane3 emits all 0.
- **Latency and continuity:** 3 back-to-back handshakes → FrameStart exactly 8 cycles apart, first at handshake+1, S_Ready high only on BitCnt==7.
- **Underflow:** deassert S_Valid after 2 frames → frame 2 repeated bit-exact, Underflow=1 from its FrameStart; the next handshake resumes new data while Underflow stays 1.
- **Mid-frame reset:** SysRst at BitCnt=3 → next cycle Data=0, Fclk=0, Underflow=0, S_Ready=1; the following handshake restarts at BitCnt=0.
- **Ramp (with ADC_SER_TESTPAT_EN):** TestPatEn=1 → deserialized values 0,1,2,... per frame on both channels; S_Ready=0 throughout.

Source files
------------

// File: rtl/adc_lvds_pkg.sv
// Shared encodings, FSM state type and frame-geometry helpers for the LVDS ADC serializer.
package adc_lvds_pkg;

    localparam int unsigned ADC_MODE_BYTE = 1;
    localparam int unsigned ADC_MODE_BIT  = 0;
    localparam int unsigned ADC_ORDER_MSB = 1;
    localparam int unsigned ADC_ORDER_LSB = 0;

    typedef enum logic [0:0] {
        AdcIdle = 1'b0,
        AdcRun  = 1'b1
    } adc_state_e;

    typedef struct packed {
        logic [31:0] n;     // serial bits per lane per frame
        logic [31:0] half;  // ceil(n/2): cycles with Fclk high
    } adc_geom_t;

    function automatic adc_geom_t adc_frame_geom(input int unsigned bits,
                                                 input int unsigned wires);
        adc_geom_t g;
        g.n    = bits / wires;
        g.half = (g.n + 32'd1) / 32'd2;
        return g;
    endfunction

    // Sample bit index carried by 'lane' at serial position 'step' of a frame.
    function automatic int unsigned adc_lane_bit_idx(input int unsigned lane,
                                                     input int unsigned step,
                                                     input int unsigned n,
                                                     input int unsigned wires,
                                                     input int unsigned mode,
                                                     input int unsigned order);
        int unsigned j;
        j = (order == ADC_ORDER_MSB) ? (n - 1 - step) : step;
        return (mode == ADC_MODE_BYTE) ? (lane * n + j) : (lane + j * wires);
    endfunction

endpackage

// File: rtl/adc_lane_shifter.sv
// One ADC channel: holds the last loaded sample and shifts it out over C_AdcWireInt lanes,
// LSB of each lane register first, after permuting bits into emission order at load time.
module adc_lane_shifter
    import adc_lvds_pkg::*;
#(
    parameter int unsigned C_AdcWireInt      = 2,
    parameter int unsigned C_AdcBits         = 16,
    parameter int unsigned C_AdcBytOrBitMode = 1,
    parameter int unsigned C_AdcMsbOrLsbFst  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    load_i,
    input  logic                    reload_i,
    input  logic [C_AdcBits-1:0]    sample_i,
    output logic [C_AdcWireInt-1:0] data_o
);

    localparam adc_geom_t   Geom = adc_frame_geom(C_AdcBits, C_AdcWireInt);
    localparam int unsigned N    = Geom.n;
    localparam int unsigned IdxW = (C_AdcBits > 1) ? $clog2(C_AdcBits) : 1;

    logic [C_AdcBits-1:0]             sample_q, sample_d, src;
    logic [C_AdcWireInt-1:0][N-1:0]   sr_q, sr_d;

    always_comb begin
        src      = reload_i ? sample_q : sample_i;
        sample_d = sample_q;
        for (int k = 0; k < int'(C_AdcWireInt); k++) begin
            sr_d[k] = sr_q[k] >> 1;
        end
        if (load_i || reload_i) begin
            sample_d = src;
            for (int k = 0; k < int'(C_AdcWireInt); k++) begin
                for (int i = 0; i < int'(N); i++) begin
                    sr_d[k][i] = src[IdxW'(adc_lane_bit_idx(k, i, N, C_AdcWireInt,
                                                            C_AdcBytOrBitMode,
                                                            C_AdcMsbOrLsbFst))];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sample_q <= '0;
            sr_q     <= '0;
        end else begin
            sample_q <= sample_d;
            sr_q     <= sr_d;
        end
    end

    for (genvar k = 0; k < C_AdcWireInt; k++) begin : g_lane
        assign data_o[k] = sr_q[k][0];
    end

endmodule

// File: rtl/adc_lvds_serializer.sv
// Multi-lane LVDS ADC serializer: framing FSM, handshake, Fclk/FrameStart and Underflow.
// Define ADC_SER_TESTPAT_EN to add the TestPatEn input and the internal ramp pattern source.
module adc_lvds_serializer
    import adc_lvds_pkg::*;
#(
    parameter int unsigned C_AdcChnls        = 2,
    parameter int unsigned C_AdcWireInt      = 2,
    parameter int unsigned C_AdcBits         = 16,
    parameter int unsigned C_AdcBytOrBitMode = 1,
    parameter int unsigned C_AdcMsbOrLsbFst  = 1
) (
    input  logic                               SysClk,
    input  logic                               SysRst,
`ifdef ADC_SER_TESTPAT_EN
    input  logic                               TestPatEn,
`endif
    input  logic [C_AdcChnls*C_AdcBits-1:0]    S_Data,
    input  logic                               S_Valid,
    output logic                               S_Ready,
    output logic [C_AdcChnls*C_AdcWireInt-1:0] Data,
    output logic                               Fclk,
    output logic                               FrameStart,
    output logic                               Underflow
);

    localparam adc_geom_t       Geom    = adc_frame_geom(C_AdcBits, C_AdcWireInt);
    localparam int unsigned     N       = Geom.n;
    localparam int unsigned     Half    = Geom.half;
    localparam int unsigned     CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    adc_state_e      state_q;
    logic [CntW-1:0] bit_cnt_q, cnt_nxt;
    logic            fclk_q, frame_start_q, underflow_q, rdy_q;
    logic            tp_en, at_last, at_bound, hs;
    logic            load_new, load_old, load_tp, load_any;

    assign at_last  = (state_q == AdcRun) && (bit_cnt_q == CntLast);
    assign at_bound = (state_q == AdcIdle) || at_last;
    assign S_Ready  = rdy_q && !tp_en;
    assign hs       = S_Valid && S_Ready;

    // S_Ready is only ever high at a frame boundary, so a handshake always loads.
    assign load_new = hs;
    assign load_tp  = tp_en && at_bound;
    assign load_old = at_last && !tp_en && !S_Valid;
    assign load_any = load_new || load_tp || load_old;

    assign cnt_nxt  = at_bound ? '0 : bit_cnt_q + CntW'(1);

    always_ff @(posedge SysClk) begin
        if (SysRst) begin
            state_q       <= AdcIdle;
            bit_cnt_q     <= '0;
            fclk_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            rdy_q         <= 1'b1;
        end else begin
            frame_start_q <= load_any;
            if (load_old) begin
                underflow_q <= 1'b1;
            end
            unique case (state_q)
                AdcIdle: begin
                    if (load_any) begin
                        state_q   <= AdcRun;
                        bit_cnt_q <= cnt_nxt;
                        fclk_q    <= (32'(cnt_nxt) < Half);
                        rdy_q     <= (cnt_nxt == CntLast);
                    end
                end
                AdcRun: begin
                    bit_cnt_q <= cnt_nxt;
                    fclk_q    <= (32'(cnt_nxt) < Half);
                    rdy_q     <= (cnt_nxt == CntLast);
                end
                default: begin
                    state_q <= AdcIdle;
                end
            endcase
        end
    end

    assign Fclk       = fclk_q;
    assign FrameStart = frame_start_q;
    assign Underflow  = underflow_q;

`ifdef ADC_SER_TESTPAT_EN
    logic [C_AdcBits-1:0] ramp_q;

    assign tp_en = TestPatEn;

    always_ff @(posedge SysClk) begin
        if (SysRst) begin
            ramp_q <= '0;
        end else if (load_tp) begin
            ramp_q <= ramp_q + C_AdcBits'(1);
        end
    end
`else
    assign tp_en = 1'b0;
`endif

    for (genvar c = 0; c < C_AdcChnls; c++) begin : g_chnl
        logic [C_AdcBits-1:0] ch_sample;

`ifdef ADC_SER_TESTPAT_EN
        assign ch_sample = load_tp ? ramp_q : S_Data[c*C_AdcBits +: C_AdcBits];
`else
        assign ch_sample = S_Data[c*C_AdcBits +: C_AdcBits];
`endif

        adc_lane_shifter #(
            .C_AdcWireInt      (C_AdcWireInt),
            .C_AdcBits         (C_AdcBits),
            .C_AdcBytOrBitMode (C_AdcBytOrBitMode),
            .C_AdcMsbOrLsbFst  (C_AdcMsbOrLsbFst)
        ) u_shifter (
            .clk_i    (SysClk),
            .rst_i    (SysRst),
            .load_i   (load_new || load_tp),
            .reload_i (load_old),
            .sample_i (ch_sample),
            .data_o   (Data[c*C_AdcWireInt +: C_AdcWireInt])
        );
    end

endmodule

// File: tb/tb_adc_lvds_serializer.sv
// Directed bench: byte/MSB and bit/LSB serializer instances driven from one stimulus stream.
module tb_adc_lvds_serializer;
    import adc_lvds_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        rdy_a, rdy_b, fclk_a, fclk_b, fs_a, fs_b, uf_a, uf_b;
    logic [3:0]  data_a, data_b;
`ifdef ADC_SER_TESTPAT_EN
    logic        tpen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_lvds_serializer #(
        .C_AdcChnls        (2),
        .C_AdcWireInt      (2),
        .C_AdcBits         (16),
        .C_AdcBytOrBitMode (ADC_MODE_BYTE),
        .C_AdcMsbOrLsbFst  (ADC_ORDER_MSB)
    ) dut_a (
        .SysClk     (clk),
        .SysRst     (rst),
`ifdef ADC_SER_TESTPAT_EN
        .TestPatEn  (tpen),
`endif
        .S_Data     (s_data),
        .S_Valid    (s_valid),
        .S_Ready    (rdy_a),
        .Data       (data_a),
        .Fclk       (fclk_a),
        .FrameStart (fs_a),
        .Underflow  (uf_a)
    );

    adc_lvds_serializer #(
        .C_AdcChnls        (2),
        .C_AdcWireInt      (2),
        .C_AdcBits         (16),
        .C_AdcBytOrBitMode (ADC_MODE_BIT),
        .C_AdcMsbOrLsbFst  (ADC_ORDER_LSB)
    ) dut_b (
        .SysClk     (clk),
        .SysRst     (rst),
`ifdef ADC_SER_TESTPAT_EN
        .TestPatEn  (tpen),
`endif
        .S_Data     (s_data),
        .S_Valid    (s_valid),
        .S_Ready    (rdy_b),
        .Data       (data_b),
        .Fclk       (fclk_b),
        .FrameStart (fs_b),
        .Underflow  (uf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected lane words pack step i at [i*4 +: 4]; called at step 0 of the frame.
    task automatic frame(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic uf, input logic nxt_valid, input logic [31:0] nxt_data);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.data_a%0d", tag, i), 32'(data_a), 32'(ea[i*4 +: 4]));
            chk($sformatf("%s.data_b%0d", tag, i), 32'(data_b), 32'(eb[i*4 +: 4]));
            chk($sformatf("%s.fclk%0d", tag, i), 32'(fclk_a), (i < 4) ? 32'd1 : 32'd0);
            chk($sformatf("%s.fs%0d", tag, i), 32'(fs_a), (i == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s.rdy%0d", tag, i), 32'(rdy_a), (i == 7) ? 32'd1 : 32'd0);
            chk($sformatf("%s.uf%0d", tag, i), 32'(uf_a), 32'(uf));
            if (i == 7) begin
                chk($sformatf("%s.rdy_b", tag), 32'(rdy_b), 32'd1);
                chk($sformatf("%s.uf_b", tag), 32'(uf_b), 32'(uf));
                s_valid = nxt_valid;
                s_data  = nxt_data;
            end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef ADC_SER_TESTPAT_EN
        tpen    = 1'b0;
`endif
        tick();
        tick();
        chk("rst.data_a", 32'(data_a), 32'd0);
        chk("rst.fclk", 32'(fclk_a), 32'd0);
        chk("rst.fs", 32'(fs_a), 32'd0);
        chk("rst.uf", 32'(uf_a), 32'd0);
        chk("rst.rdy", 32'(rdy_a), 32'd1);
        rst = 1'b0;
        tick();
        chk("idle.rdy", 32'(rdy_a), 32'd1);
        chk("idle.data_b", 32'(data_b), 32'd0);
        chk("idle.fs", 32'(fs_a), 32'd0);

        // Back-to-back frames, then an underflow repeat, then resumed data.
        s_valid = 1'b1;
        s_data  = 32'h0001_A5C3;
        tick();
        frame("f1", 32'h7120_0213, 32'h2211_3007, 1'b0, 1'b1, 32'hFFFF_0000);
        frame("f2", 32'hCCCC_CCCC, 32'hCCCC_CCCC, 1'b0, 1'b1, 32'h0000_FF00);
        frame("f3", 32'h2222_2222, 32'h3333_0000, 1'b0, 1'b0, 32'h0000_FF00);
        frame("f4", 32'h2222_2222, 32'h3333_0000, 1'b1, 1'b1, 32'h8000_0001);
        frame("f5", 32'h1000_0008, 32'h8000_0001, 1'b1, 1'b1, 32'hFFFF_0000);

        // Mid-frame reset at BitCnt 3 of an all-ones-upper frame.
        tick();
        tick();
        tick();
        chk("mid.pre_data_a", 32'(data_a), 32'hC);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'h0001_A5C3;
        tick();
        chk("mid.data_a", 32'(data_a), 32'd0);
        chk("mid.data_b", 32'(data_b), 32'd0);
        chk("mid.fclk", 32'(fclk_a), 32'd0);
        chk("mid.fs", 32'(fs_a), 32'd0);
        chk("mid.uf", 32'(uf_a), 32'd0);
        chk("mid.rdy", 32'(rdy_a), 32'd1);
        tick();
        chk("rsths.fs", 32'(fs_a), 32'd0);
        chk("rsths.data_a", 32'(data_a), 32'd0);
        rst = 1'b0;
        tick();
        frame("f7", 32'h7120_0213, 32'h2211_3007, 1'b0, 1'b0, 32'h0001_A5C3);

`ifdef ADC_SER_TESTPAT_EN
        rst     = 1'b1;
        s_valid = 1'b0;
        tick();
        rst  = 1'b0;
        tpen = 1'b1;
        tick();
        for (int v = 0; v < 3; v++) begin
            logic [15:0] vv;
            vv = 16'(v);
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("ramp%0d.data_a%0d", v, i), 32'(data_a),
                    32'({vv[15-i], vv[7-i], vv[15-i], vv[7-i]}));
                chk($sformatf("ramp%0d.rdy%0d", v, i), 32'(rdy_a), 32'd0);
                tick();
            end
        end
        chk("ramp.uf", 32'(uf_a), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
